mult_mod_pipe: RTL and testbench

- Pipelined, multi-lane modular multiplier for the NTT butterfly datapath; successor to the fixed two-lane combinational multiply/modulo pair.
- Each lane computes (a * w) mod Q using Barrett reduction, with valid/ready flow control, a per-beat bypass mode and a sideband tag.
- Sits between the twiddle/operand fetch and the butterfly add/sub stage.

---
 rtl/mult_mod_pipe_pkg.sv | 28 ++
 rtl/mult_mod_pipe_if.sv | 33 +++
 rtl/mult_mod_pipe_lane.sv | 86 ++++++++
 rtl/mult_mod_pipe.sv | 59 +++++
 tb/tb_mult_mod_pipe.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_mod_pipe_pkg.sv
// Shared constants and elaboration-time helpers for the modular multiplier.
//   Q_DEFAULT / WIDTH_DEFAULT : default modulus and lane width
//   clog2(v)                  : ceil(log2(v)), usable in constant expressions
//   barrett_mu(q, k)          : floor(2^(2k) / q), the Barrett constant
//   lane(i, width)            : LSB position of lane i in a packed lane bus
package mult_mod_pkg;

  localparam int unsigned Q_DEFAULT     = 12289;
  localparam int unsigned WIDTH_DEFAULT = 18;

  function automatic int unsigned clog2(input longint unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 64; i++) begin
      if ((64'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic longint unsigned barrett_mu(input longint unsigned q, input int unsigned k);
    return (64'd1 << (2 * k)) / q;
  endfunction

  function automatic int unsigned lane(input int unsigned i, input int unsigned width);
    return i * width;
  endfunction

endpackage

// File: rtl/mult_mod_pipe_if.sv
// Operand/result channel of the modular multiplier.
//   in_*  : operand beat (valid/ready), mode, packed lanes a and w, tag
//   out_* : result beat (valid/ready), packed lanes r, tag, per-lane range error
// master = producer of operands / consumer of results, slave = the multiplier.
interface mult_mod_pipe_if
  import mult_mod_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT,
  parameter int unsigned LANES = 2,
  parameter int unsigned TAG_W = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic                   in_mode;
  logic [LANES*WIDTH-1:0] in_a;
  logic [LANES*WIDTH-1:0] in_w;
  logic [TAG_W-1:0]       in_tag;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*WIDTH-1:0] out_r;
  logic [TAG_W-1:0]       out_tag;
  logic [LANES-1:0]       out_err;

  modport master (
    output in_valid, in_mode, in_a, in_w, in_tag, out_ready,
    input  in_ready, out_valid, out_r, out_tag, out_err
  );

  modport slave (
    input  in_valid, in_mode, in_a, in_w, in_tag, out_ready,
    output in_ready, out_valid, out_r, out_tag, out_err
  );
endinterface

// File: rtl/mult_mod_pipe_lane.sv
// One lane of the pipelined Barrett modular multiplier: r = (a * w) mod Q.
//   clk, rst_n : clock, synchronous active-low reset
//   en         : global advance; every register holds when low
//   s2_valid   : a real beat sits in S2; bubbles load zero into the output
//   mode       : 0 = multiply-mod, 1 = bypass (r = a)
//   a, w       : lane operands
//   r, err     : registered result and range flag (a >= Q or w >= Q)
module barrett_lane
  import mult_mod_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT,
  parameter int unsigned Q     = Q_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             s2_valid,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] w,
  output logic [WIDTH-1:0] r,
  output logic             err
);
  localparam int unsigned K  = clog2(64'(Q));
  localparam int unsigned PW = 2 * K;      // full product
  localparam int unsigned QW = K + 1;      // Barrett quotient estimate
  localparam int unsigned RW = K + 2;      // remainder before correction (< 3Q)
  localparam int unsigned XW = 2 * K + 3;  // (p >> (K-1)) * MU without overflow
  localparam logic [RW-1:0] Q_R  = RW'(Q);
  localparam logic [XW-1:0] MU_X = XW'(barrett_mu(64'(Q), K));

  logic [PW-1:0]    p1;
  logic [RW-1:0]    p2;
  logic [QW-1:0]    q2;
  logic             mode1, mode2, err1, err2;
  logic [WIDTH-1:0] a1, a2;

  logic [PW-1:0]    p_c;
  logic             err_c;
  logic [XW-1:0]    x_c;
  logic [QW-1:0]    q_c;
  logic [RW-1:0]    qq_c, r0_c, r1_c, r2_c;
  logic [WIDTH-1:0] res_c;

  // Stage datapaths; the remainder only needs the low K+2 bits of p and q*Q.
  always_comb begin
    p_c   = PW'(a[K-1:0]) * PW'(w[K-1:0]);
    err_c = !mode && ((a >= WIDTH'(Q)) || (w >= WIDTH'(Q)));
    x_c   = XW'(p1 >> (K - 1)) * MU_X;
    q_c   = QW'(x_c >> (K + 1));
    qq_c  = RW'(q2) * Q_R;
    r0_c  = p2 - qq_c;
    r1_c  = (r0_c >= Q_R) ? (r0_c - Q_R) : r0_c;
    r2_c  = (r1_c >= Q_R) ? (r1_c - Q_R) : r1_c;
    res_c = mode2 ? a2 : WIDTH'(r2_c);
  end

  // S1 -> S2 -> output, all gated by the shared advance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p1    <= '0;
      mode1 <= 1'b0;
      err1  <= 1'b0;
      a1    <= '0;
      p2    <= '0;
      q2    <= '0;
      mode2 <= 1'b0;
      err2  <= 1'b0;
      a2    <= '0;
      r     <= '0;
      err   <= 1'b0;
    end else if (en) begin
      p1    <= p_c;
      mode1 <= mode;
      err1  <= err_c;
      a1    <= a;
      p2    <= RW'(p1);
      q2    <= q_c;
      mode2 <= mode1;
      err2  <= err1;
      a2    <= a1;
      r     <= s2_valid ? res_c : '0;
      err   <= s2_valid & err2;
    end
  end
endmodule

// File: rtl/mult_mod_pipe.sv
// Multi-lane pipelined modular multiplier for the NTT butterfly datapath.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : operand/result channel (slave side), LANES lanes of WIDTH bits
// Three stages, latency 3, one beat per cycle; a single global stall freezes
// every stage whenever the output holds a beat the consumer has not taken.
module mult_mod_pipe
  import mult_mod_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT,
  parameter int unsigned LANES = 2,
  parameter int unsigned Q     = Q_DEFAULT,
  parameter int unsigned TAG_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  mult_mod_pipe_if.slave bus
);
  logic             adv;
  logic [2:0]       vld;   // vld[2] is the output stage
  logic [TAG_W-1:0] tag1, tag2, tag3;

  assign adv          = !vld[2] || bus.out_ready;
  assign bus.in_ready = adv;
  assign bus.out_valid = vld[2];
  assign bus.out_tag   = tag3;

  // Valid chain and tag pipeline; the output tag reads zero for bubbles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld  <= '0;
      tag1 <= '0;
      tag2 <= '0;
      tag3 <= '0;
    end else if (adv) begin
      vld  <= {vld[1:0], bus.in_valid};
      tag1 <= bus.in_tag;
      tag2 <= tag1;
      tag3 <= vld[1] ? tag2 : '0;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam int unsigned LSB = lane(i, WIDTH);
    barrett_lane #(
      .WIDTH (WIDTH),
      .Q     (Q)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (adv),
      .s2_valid (vld[1]),
      .mode     (bus.in_mode),
      .a        (bus.in_a[LSB +: WIDTH]),
      .w        (bus.in_w[LSB +: WIDTH]),
      .r        (bus.out_r[LSB +: WIDTH]),
      .err      (bus.out_err[i])
    );
  end
endmodule

// File: tb/tb_mult_mod_pipe.sv
// Directed bench for mult_mod_pipe: a default 2-lane Q=12289 instance and a
// 4-lane Q=65537 instance, checked against hand values and an (a*w)%Q model.
module tb_mult_mod_pipe;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mult_mod_pipe_if #(.WIDTH(18), .LANES(2), .TAG_W(8)) if0 ();
  mult_mod_pipe_if #(.WIDTH(18), .LANES(4), .TAG_W(8)) if1 ();

  mult_mod_pipe #(.WIDTH(18), .LANES(2), .Q(12289), .TAG_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave));
  mult_mod_pipe #(.WIDTH(18), .LANES(4), .Q(65537), .TAG_W(8)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave));

  // scratch for sweeps and backpressure
  logic [35:0] expq0[$];
  logic [71:0] expq1[$];
  logic [35:0] e0;
  logic [71:0] e1;
  logic [17:0] ra, rw;
  logic [71:0] va, vw, ve;
  int          bubbles;
  logic [35:0] bp_r[6];
  logic [7:0]  bp_tag[6];
  int          bp_sent, bp_got, stall;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [17:0] mm(input logic [17:0] a, input logic [17:0] w, input int unsigned q);
    return 18'((64'(a) * 64'(w)) % 64'(q));
  endfunction

  // One isolated beat through the 2-lane instance with full latency checks.
  task automatic beat0(input logic m, input logic [35:0] a, input logic [35:0] w,
                       input logic [7:0] tg, input logic [35:0] er, input logic [1:0] ee,
                       input string nm);
    if0.in_mode = m; if0.in_a = a; if0.in_w = w; if0.in_tag = tg;
    if0.in_valid = 1'b1; if0.out_ready = 1'b1;
    #1;
    chk({nm, "_in_ready"}, 128'(if0.in_ready), 128'(1'b1));
    tick();
    if0.in_valid = 1'b0;
    tick();
    chk({nm, "_early_valid"}, 128'(if0.out_valid), 128'(1'b0));
    tick();
    chk({nm, "_valid"}, 128'(if0.out_valid), 128'(1'b1));
    chk({nm, "_r"},     128'(if0.out_r),     128'(er));
    chk({nm, "_tag"},   128'(if0.out_tag),   128'(tg));
    chk({nm, "_err"},   128'(if0.out_err),   128'(ee));
    tick();
    chk({nm, "_after_valid"}, 128'(if0.out_valid), 128'(1'b0));
    chk({nm, "_after_r"},     128'(if0.out_r),     128'(0));
  endtask

  task automatic beat1(input logic [71:0] a, input logic [71:0] w, input logic [7:0] tg,
                       input logic [71:0] er, input logic [3:0] ee, input string nm);
    if1.in_mode = 1'b0; if1.in_a = a; if1.in_w = w; if1.in_tag = tg;
    if1.in_valid = 1'b1; if1.out_ready = 1'b1;
    tick();
    if1.in_valid = 1'b0;
    tick();
    tick();
    chk({nm, "_valid"}, 128'(if1.out_valid), 128'(1'b1));
    chk({nm, "_r"},     128'(if1.out_r),     128'(er));
    chk({nm, "_tag"},   128'(if1.out_tag),   128'(tg));
    chk({nm, "_err"},   128'(if1.out_err),   128'(ee));
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    if0.in_valid = 1'b0; if0.in_mode = 1'b0; if0.in_a = '0; if0.in_w = '0;
    if0.in_tag = '0; if0.out_ready = 1'b1;
    if1.in_valid = 1'b0; if1.in_mode = 1'b0; if1.in_a = '0; if1.in_w = '0;
    if1.in_tag = '0; if1.out_ready = 1'b1;
    tick();
    tick();

    // reset state
    chk("rst_out_valid", 128'(if0.out_valid), 128'(1'b0));
    chk("rst_out_r",     128'(if0.out_r),     128'(0));
    chk("rst_out_tag",   128'(if0.out_tag),   128'(0));
    chk("rst_out_err",   128'(if0.out_err),   128'(0));
    chk("rst_in_ready",  128'(if0.in_ready),  128'(1'b1));
    chk("rst1_out_valid", 128'(if1.out_valid), 128'(1'b0));
    chk("rst1_out_r",     128'(if1.out_r),     128'(0));
    rst_n = 1'b1;
    tick();

    // directed beats: lane vectors are {lane1, lane0}
    beat0(1'b0, {18'd12288, 18'd2},    {18'd12288, 18'd3},     8'h5A, {18'd1, 18'd6},         2'b00, "lat");
    beat0(1'b0, {18'd0, 18'd5000},     {18'd12288, 18'd5000},  8'h3C, {18'd0, 18'd4174},      2'b00, "reduce");
    beat0(1'b1, {18'h12345, 18'h3FFFF}, {18'h3FFFF, 18'd5},    8'hB1, {18'h12345, 18'h3FFFF}, 2'b00, "bypass");
    beat0(1'b0, {18'd7, 18'd12289},    {18'd8, 18'd1},         8'hE1, {18'd56, 18'd0},        2'b01, "err_lane0");
    beat0(1'b0, {18'd2, 18'd3},        {18'd20000, 18'd4},     8'hE2, {18'd7232, 18'd12},     2'b10, "err_lane1");

    // random sweep, one beat per cycle, no bubbles once the pipe fills
    bubbles = 0;
    if0.out_ready = 1'b1;
    for (int c = 0; c < 10003; c++) begin
      if (c < 10000) begin
        va = '0; vw = '0; ve = '0;
        for (int l = 0; l < 2; l++) begin
          ra = 18'($urandom_range(0, 12288));
          rw = 18'($urandom_range(0, 12288));
          va[l*18 +: 18] = ra;
          vw[l*18 +: 18] = rw;
          ve[l*18 +: 18] = mm(ra, rw, 12289);
        end
        if0.in_mode = 1'b0; if0.in_a = va[35:0]; if0.in_w = vw[35:0];
        if0.in_tag = 8'(c); if0.in_valid = 1'b1;
      end else begin
        if0.in_valid = 1'b0;
      end
      #1;
      if (if0.out_valid) begin
        e0 = expq0.pop_front();
        chk("sweep0_r", 128'(if0.out_r), 128'(e0));
      end else if (c >= 3) begin
        bubbles++;
      end
      if (if0.in_valid && if0.in_ready) expq0.push_back(ve[35:0]);
      tick();
    end
    chk("sweep0_bubbles", 128'(bubbles), 128'(0));
    chk("sweep0_drained", 128'(expq0.size()), 128'(0));

    // backpressure: six beats, consumer stalls four cycles after the first result
    for (int i = 0; i < 6; i++) begin
      bp_r[i]   = {mm(18'(1000 * (i + 1)), 18'd13, 12289), mm(18'(100 + i), 18'd7, 12289)};
      bp_tag[i] = 8'(8'h10 + i);
    end
    bp_sent = 0; bp_got = 0; stall = 0;
    for (int c = 0; c < 40 && bp_got < 6; c++) begin
      if0.out_ready = (stall == 0);
      if (bp_sent < 6) begin
        if0.in_mode = 1'b0;
        if0.in_a = {18'(1000 * (bp_sent + 1)), 18'(100 + bp_sent)};
        if0.in_w = {18'd13, 18'd7};
        if0.in_tag = bp_tag[bp_sent];
        if0.in_valid = 1'b1;
      end else begin
        if0.in_valid = 1'b0;
      end
      #1;
      if (stall > 0) begin
        chk("bp_in_ready_stalled", 128'(if0.in_ready),  128'(1'b0));
        chk("bp_valid_held",       128'(if0.out_valid), 128'(1'b1));
        chk("bp_r_held",           128'(if0.out_r),     128'(bp_r[bp_got]));
        chk("bp_tag_held",         128'(if0.out_tag),   128'(bp_tag[bp_got]));
        stall--;
      end
      if (if0.out_valid && if0.out_ready) begin
        chk("bp_r",   128'(if0.out_r),   128'(bp_r[bp_got]));
        chk("bp_tag", 128'(if0.out_tag), 128'(bp_tag[bp_got]));
        chk("bp_err", 128'(if0.out_err), 128'(0));
        bp_got++;
        if (bp_got == 1) stall = 4;
      end
      if (if0.in_valid && if0.in_ready) bp_sent++;
      tick();
    end
    if0.in_valid = 1'b0;
    if0.out_ready = 1'b1;
    chk("bp_sent", 128'(bp_sent), 128'(6));
    chk("bp_got",  128'(bp_got),  128'(6));
    #1;
    chk("bp_no_dup", 128'(if0.out_valid), 128'(1'b0));
    tick();
    tick();
    chk("bp_no_dup_late", 128'(if0.out_valid), 128'(1'b0));

    // reset with two beats in flight
    if0.in_mode = 1'b0; if0.in_a = {18'd9, 18'd9}; if0.in_w = {18'd9, 18'd9};
    if0.in_tag = 8'hA1; if0.in_valid = 1'b1;
    tick();
    if0.in_tag = 8'hA2;
    tick();
    if0.in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_valid", 128'(if0.out_valid), 128'(1'b0));
    chk("midrst_r",     128'(if0.out_r),     128'(0));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("midrst_no_stale", 128'(if0.out_valid), 128'(1'b0));
    end
    beat0(1'b0, {18'd12288, 18'd3}, {18'd2, 18'd4}, 8'h77, {18'd12287, 18'd12}, 2'b00, "post_rst");

    // 4-lane Q=65537 instance: {lane3, lane2, lane1, lane0}
    beat1({18'd12345, 18'd256, 18'd65536, 18'd65536}, {18'd0, 18'd256, 18'd2, 18'd65536},
          8'hC4, {18'd0, 18'd65536, 18'd65535, 18'd1}, 4'b0000, "q65537");
    beat1({18'd1, 18'd1, 18'd1, 18'd65537}, {18'd1, 18'd1, 18'd1, 18'd1},
          8'hC5, {18'd1, 18'd1, 18'd1, 18'd0}, 4'b0001, "q65537_err");

    bubbles = 0;
    if1.out_ready = 1'b1;
    for (int c = 0; c < 1003; c++) begin
      if (c < 1000) begin
        va = '0; vw = '0; ve = '0;
        for (int l = 0; l < 4; l++) begin
          ra = 18'($urandom_range(0, 65536));
          rw = 18'($urandom_range(0, 65536));
          va[l*18 +: 18] = ra;
          vw[l*18 +: 18] = rw;
          ve[l*18 +: 18] = mm(ra, rw, 65537);
        end
        if1.in_mode = 1'b0; if1.in_a = va; if1.in_w = vw;
        if1.in_tag = 8'(c); if1.in_valid = 1'b1;
      end else begin
        if1.in_valid = 1'b0;
      end
      #1;
      if (if1.out_valid) begin
        e1 = expq1.pop_front();
        chk("sweep1_r", 128'(if1.out_r), 128'(e1));
      end else if (c >= 3) begin
        bubbles++;
      end
      if (if1.in_valid && if1.in_ready) expq1.push_back(ve);
      tick();
    end
    chk("sweep1_bubbles", 128'(bubbles), 128'(0));
    chk("sweep1_drained", 128'(expq1.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
